// File: rtl/ex_result_buf_pkg.sv
// rtl/ex_result_buf_pkg.sv - shared widths, state encodings and entry sizing for the EX result skid buffer
package ex_result_buf_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int DEST_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

`ifdef RESULT_FLAGS_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 0;
`endif

  // Packed entry layout: {result, dest, wr_en[, zero, neg]}
  function automatic int entry_width(input int dw, input int destw);
    return dw + destw + 1 + FLAG_W;
  endfunction

endpackage

// File: rtl/ex_result_buf_entry.sv
// rtl/ex_result_buf_entry.sv - load-enabled entry register (module ex_buf_entry), async reset to zero
module ex_buf_entry #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= '0;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/ex_result_buf.sv
// rtl/ex_result_buf.sv - two-entry EX->MEM skid buffer with flush; RESULT_FLAGS_EN adds stored zero/neg flags
// in_ready depends only on registered state, so there is no out_ready->in_ready path.
module ex_result_buf
  import ex_result_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEST_WIDTH = DEST_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_wr_en,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_wr_en,
`ifdef RESULT_FLAGS_EN
  output logic                  out_zero,
  output logic                  out_neg,
`endif
  output logic [1:0]            occupancy
);

  localparam int EW = entry_width(DATA_WIDTH, DEST_WIDTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_pop;
  logic          w_head_load;
  logic          w_tail_load;
  logic          w_head_from_tail;
  logic [EW-1:0] w_in_entry;
  logic [EW-1:0] w_head_d;
  logic [EW-1:0] w_head_q;
  logic [EW-1:0] w_tail_q;

  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign occupancy = r_state;
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

`ifdef RESULT_FLAGS_EN
  assign w_in_entry = {in_result, in_dest, in_wr_en, (in_result == '0), in_result[DATA_WIDTH-1]};
`else
  assign w_in_entry = {in_result, in_dest, in_wr_en};
`endif

  // Flush wins over any same-cycle accept or pop and leaves entry data untouched.
  always_comb begin
    w_state_nxt      = r_state;
    w_head_load      = 1'b0;
    w_tail_load      = 1'b0;
    w_head_from_tail = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_head_load = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_head_load = 1'b1;
          end else if (w_accept) begin
            w_tail_load = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_head_load      = 1'b1;
            w_head_from_tail = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_head_d = w_head_from_tail ? w_tail_q : w_in_entry;

  ex_buf_entry #(.W(EW)) u_head (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_head_load),
    .i_d    (w_head_d),
    .o_q    (w_head_q)
  );

  ex_buf_entry #(.W(EW)) u_tail (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_tail_load),
    .i_d    (w_in_entry),
    .o_q    (w_tail_q)
  );

  assign out_result = w_head_q[EW-1 -: DATA_WIDTH];
  assign out_dest   = w_head_q[EW-1-DATA_WIDTH -: DEST_WIDTH];
  assign out_wr_en  = w_head_q[FLAG_W];
`ifdef RESULT_FLAGS_EN
  assign out_zero   = w_head_q[1];
  assign out_neg    = w_head_q[0];
`endif

endmodule

// File: tb/tb_ex_result_buf.sv
// tb/tb_ex_result_buf.sv - scoreboard bench for ex_result_buf; flag checks build when RESULT_FLAGS_EN is defined
module tb_ex_result_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [2:0]  in_dest;
  logic        in_wr_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_dest;
  logic        out_wr_en;
  logic [1:0]  occupancy;
`ifdef RESULT_FLAGS_EN
  logic        out_zero;
  logic        out_neg;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  ex_result_buf dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_dest    (in_dest),
    .in_wr_en   (in_wr_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dest   (out_dest),
    .out_wr_en  (out_wr_en),
`ifdef RESULT_FLAGS_EN
    .out_zero   (out_zero),
    .out_neg    (out_neg),
`endif
    .occupancy  (occupancy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] r, input logic [2:0] d, input logic w);
    in_valid  = 1'b1;
    in_result = r;
    in_dest   = d;
    in_wr_en  = w;
    exp_q.push_back({r, d, w});
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      cyc();
      n++;
    end
    chk({nm, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_vld"}, 32'(out_valid), 32'd0);
  endtask

  // Monitor: every popped head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mon_unexpected: got %0h expected nothing", out_result);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("mon_data", {12'd0, out_result, out_dest, out_wr_en}, {12'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_dest = '0; in_wr_en = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    cyc();

    // 1. single pass
    out_ready = 1'b1;
    drive(16'h8001, 3'd3, 1'b1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_result", 32'(out_result), 32'h8001);
    chk("t1_dest", 32'(out_dest), 32'd3);
    cyc();
    @(negedge clk);
    chk("t1_empty", 32'(out_valid), 32'd0);
    cyc();

    // 2. backpressure
    out_ready = 1'b0;
    drive(16'h1111, 3'd1, 1'b1); cyc();
    drive(16'h2222, 3'd2, 1'b0); cyc();
    in_valid = 1'b1; in_result = 16'h3333; in_dest = 3'd5; in_wr_en = 1'b1;
    @(negedge clk);
    chk("t2_ready", 32'(in_ready), 32'd0);
    chk("t2_occ", 32'(occupancy), 32'd2);
    cyc();
    @(negedge clk);
    chk("t2_hold_occ", 32'(occupancy), 32'd2);
    chk("t2_hold_res", 32'(out_result), 32'h1111);
    cyc();
    out_ready = 1'b1;
    exp_q.push_back({16'h3333, 3'd5, 1'b1});
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 5) begin
        cyc();
        @(negedge clk);
        n++;
      end
      chk("t2_reready", 32'(in_ready), 32'd1);
    end
    cyc();
    in_valid = 1'b0;
    drain("t2");

    // 3. streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(16'(i), 3'(i), i[0]);
      @(negedge clk);
      if (i > 1) begin
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_occ", 32'(occupancy), 32'd1);
      end
      cyc();
    end
    in_valid = 1'b0;
    drain("t3");

    // 4. flush
    out_ready = 1'b0;
    drive(16'hA1A1, 3'd1, 1'b1); cyc();
    drive(16'hA2A2, 3'd2, 1'b1); cyc();
    in_valid = 1'b1; in_result = 16'hABCD; in_dest = 3'd7; in_wr_en = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_occ", 32'(occupancy), 32'd0);
    chk("t4_ready", 32'(in_ready), 32'd1);
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stay_empty", 32'(out_valid), 32'd0);
      cyc();
    end

    // 5. async reset mid-operation
    out_ready = 1'b0;
    drive(16'hB1B1, 3'd1, 1'b1); cyc();
    drive(16'hB2B2, 3'd2, 1'b1); cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_full", 32'(occupancy), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_result", 32'(out_result), 32'd0);
    chk("t5_occ", 32'(occupancy), 32'd0);
    exp_q.delete();
    cyc();
    rst = 1'b0;
    cyc();

`ifdef RESULT_FLAGS_EN
    // 6. flags
    out_ready = 1'b1;
    drive(16'h0000, 3'd4, 1'b1); cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_zero0", 32'(out_zero), 32'd1);
    chk("t6_neg0", 32'(out_neg), 32'd0);
    cyc();
    drive(16'h8000, 3'd4, 1'b1); cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_zero1", 32'(out_zero), 32'd0);
    chk("t6_neg1", 32'(out_neg), 32'd1);
    cyc();
    drain("t6");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
